// File: rtl/spu_draw_pkg.sv
// Shared constants and types for the SPU draw engine.
// Optional fb backpressure is enabled by SPU_FB_BACKPRESSURE_EN.
package spu_draw_pkg;
  localparam logic [3:0] OP_RECT  = 4'b0101;
  localparam logic [3:0] OP_CLEAR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } draw_state_t;

  localparam int FB_W_DEF   = 320;
  localparam int FB_H_DEF   = 240;
  localparam int ADDR_W_DEF = 17;
  localparam int PIX_W_DEF  = 8;

  localparam int CTL_OP_HI  = 11;
  localparam int CTL_OP_LO  = 8;
  localparam int CTL_COL_HI = 7;
  localparam int CTL_COL_LO = 0;
endpackage

// File: rtl/spu_raster_counter.sv
// Row-major raster walker: x inner loop, row base stepped by FB_W.
// Produces the next linear address without any multiply.
module spu_raster_counter
  import spu_draw_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [16:0]       x_start,
  input  logic [16:0]       x_end,
  input  logic [16:0]       y_start,
  input  logic [16:0]       y_end,
  input  logic [ADDR_W-1:0] row_base_init,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);
  logic [16:0] x, y, xs, xe, ye;
  logic [ADDR_W-1:0] row_base;
  logic row_end;

  assign row_end = (x + 17'd1) == xe;
  assign last    = row_end && ((y + 17'd1) == ye);

  always_comb begin
    if (row_end)
      next_addr = row_base + ADDR_W'(FB_W) + ADDR_W'(xs);
    else
      next_addr = row_base + ADDR_W'(x + 17'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x        <= '0;
      y        <= '0;
      xs       <= '0;
      xe       <= '0;
      ye       <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= x_start;
      y        <= y_start;
      xs       <= x_start;
      xe       <= x_end;
      ye       <= y_end;
      row_base <= row_base_init;
    end else if (advance) begin
      if (row_end) begin
        x        <= xs;
        y        <= y + 17'd1;
        row_base <= row_base + ADDR_W'(FB_W);
      end else begin
        x <= x + 17'd1;
      end
    end
  end
endmodule

// File: rtl/spu_draw_engine.sv
// SPU DRW responder: clips RECT/CLEAR and writes one pixel per cycle.
// Define SPU_FB_BACKPRESSURE_EN to add the fb_ready stall input.
module spu_draw_engine
  import spu_draw_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [11:0]       spu_control,
  input  logic [31:0]       src_a,
  input  logic [31:0]       src_b,
`ifdef SPU_FB_BACKPRESSURE_EN
  input  logic              fb_ready,
`endif
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_wdata,
  output logic              busy,
  output logic              done
);
  localparam logic [16:0] FBW = 17'(FB_W);
  localparam logic [16:0] FBH = 17'(FB_H);

  draw_state_t state;
  logic [3:0] op_q;
  logic [PIX_W-1:0] colour_q;
  logic [15:0] x0_q, y0_q, w_q, h_q;

  logic is_clear, is_rect, empty, fire, last;
  logic [16:0] x_sum, y_sum, x_s, y_s, x_e, y_e;
  logic [ADDR_W-1:0] row_init, start_addr, next_addr;

  always_comb begin
    is_clear   = op_q == OP_CLEAR;
    is_rect    = op_q == OP_RECT;
    x_sum      = {1'b0, x0_q} + {1'b0, w_q};
    y_sum      = {1'b0, y0_q} + {1'b0, h_q};
    x_s        = is_clear ? '0 : {1'b0, x0_q};
    y_s        = is_clear ? '0 : {1'b0, y0_q};
    x_e        = is_clear ? FBW : ((x_sum > FBW) ? FBW : x_sum);
    y_e        = is_clear ? FBH : ((y_sum > FBH) ? FBH : y_sum);
    empty      = !is_clear && (!is_rect || x_s >= FBW || y_s >= FBH ||
                               w_q == '0 || h_q == '0);
    row_init   = ADDR_W'(32'(y_s) * 32'(FB_W));
    start_addr = row_init + ADDR_W'(x_s);
  end

`ifdef SPU_FB_BACKPRESSURE_EN
  assign fire = fb_we & fb_ready;
`else
  assign fire = fb_we;
`endif

  spu_raster_counter #(
    .FB_W  (FB_W),
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .load         (state == SETUP),
    .advance      (fire),
    .x_start      (x_s),
    .x_end        (x_e),
    .y_start      (y_s),
    .y_end        (y_e),
    .row_base_init(row_init),
    .next_addr    (next_addr),
    .last         (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      op_q      <= '0;
      colour_q  <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (cmd_valid) begin
          op_q      <= spu_control[CTL_OP_HI:CTL_OP_LO];
          colour_q  <= PIX_W'(spu_control[CTL_COL_HI:CTL_COL_LO]);
          x0_q      <= src_a[31:16];
          y0_q      <= src_a[15:0];
          w_q       <= src_b[31:16];
          h_q       <= src_b[15:0];
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= SETUP;
        end
        SETUP: begin
          fb_wdata <= colour_q;
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            fb_we   <= 1'b1;
            fb_addr <= start_addr;
            state   <= DRAW;
          end
        end
        DRAW: if (fire) begin
          if (last) begin
            fb_we <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            fb_addr <= next_addr;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spu_draw_engine.md
Name: spu_draw_engine

Overview:
- Responder for the DRW path of the SPU control interface.
- When the control unit issues a draw instruction (SPUControl = {op[3:0], colorShape[7:0]} with memory write set), this block accepts it and rasterises it into the graphics frame buffer.
- Writes one pixel per cycle and holds off the core with cmd_ready until the command completes.
- Sits between the control unit / register-file operand outputs and the frame-buffer RAM write port.

Parameters:
- FB_W, 320, frame-buffer width in pixels.
- FB_H, 240, frame-buffer height in pixels.
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- PIX_W, 8, pixel width (colorShape is the pixel value).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  draw command present (MemW & DRW opcode).
- cmd_ready  out  1  engine idle and able to accept a command.
- spu_control  in  12  [11:8] op, [7:0] colorShape (pixel colour).
- src_a  in  32  [31:16] x0, [15:0] y0, unsigned.
- src_b  in  32  [31:16] width, [15:0] height, unsigned.
- fb_we  out  1  frame-buffer write strobe.
- fb_addr  out  ADDR_W  linear address y*FB_W + x.
- fb_wdata  out  PIX_W  pixel data.
- busy  out  1  command in progress (= ~cmd_ready).
- done  out  1  one-cycle pulse when a command finishes.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - fb_we=0, fb_addr=0, fb_wdata=0, done=0, busy=0, cmd_ready=1.
  - Takes effect immediately, including mid-command. Any partially drawn command is abandoned with no done pulse.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready (IDLE only).
  - spu_control, src_a and src_b are registered at acceptance and may change afterwards.
  - cmd_valid while busy is ignored; the core stalls and holds valid.
- Opcodes:
  - OP_RECT=4'b0101: fill rectangle [x0, x0+w) x [y0, y0+h) with colour.
  - OP_CLEAR=4'b1100: fill whole buffer with colour; src_a and src_b are ignored.
  - Any other op: accepted as a zero-pixel command.
- FSM:
  - IDLE -> SETUP on accept.
  - SETUP -> DRAW if the clipped area is non-empty, else -> DONE.
  - DRAW -> DONE after the last pixel.
  - DONE -> IDLE, with done=1 for exactly that cycle.
- Clipping, computed in SETUP with 17-bit intermediates:
  - x_end = min(x0+w, FB_W); y_end = min(y0+h, FB_H).
  - The area is empty if x0>=FB_W, y0>=FB_H, w==0 or h==0.
  - CLEAR sets x0=y0=0, x_end=FB_W, y_end=FB_H.
- Raster order: row-major, x inner loop.
  - row_base = y0*FB_W (constant multiply in SETUP); then row_base += FB_W per row.
  - fb_addr = row_base + x. No multiply in the DRAW loop.
- Timing:
  - Accept at edge T. SETUP occupies cycle T+1.
  - The N writes have fb_we=1 in cycles T+2 .. T+N+1.
  - done pulses in cycle T+N+2; cmd_ready returns at T+N+3.
  - For an empty area, done pulses in cycle T+2.
- Outputs:
  - fb_wdata is held at colour throughout DRAW.
  - fb_we=0 outside DRAW.
  - fb_addr is registered, not combinational from the counters.

Optional Feature:
- Macro: SPU_FB_BACKPRESSURE_EN.
- Defined:
  - Adds input port fb_ready (1 bit).
  - A write completes only in a cycle with fb_we & fb_ready.
  - While fb_ready=0, fb_we, fb_addr and fb_wdata hold and the counters do not advance.
  - done is delayed by the number of stall cycles.
- Undefined: the port is absent and every fb_we cycle completes.

Decomposition:
- Package spu_draw_pkg holds:
  - OP_RECT and OP_CLEAR constants.
  - State enum draw_state_t {IDLE, SETUP, DRAW, DONE}.
  - Default FB_W, FB_H, ADDR_W and PIX_W localparams.
  - The SPUControl field-slice localparams.
- One sub-module, spu_raster_counter:
  - Holds x, row_base and y counters, with load, advance and last-pixel flag.
  - The FSM and clipping stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> fb_we=0, fb_addr=0, done=0, cmd_ready=1; assert reset mid-DRAW -> fb_we=0 in the same cycle and IDLE after release.
- RECT x0=10, y0=2, w=3, h=2, colour 0xA5 accepted at T -> writes to 650, 651, 652, 970, 971, 972 in cycles T+2..T+7, all with data 0xA5; done at T+8.
- Clipped RECT x0=318, y0=239, w=5, h=5 -> exactly two writes, to 76798 and 76799; done at T+4.
- Empty: RECT w=0, and separately x0=400, plus op 4'b0011 -> zero writes, done at T+2, cmd_ready at T+3.
- CLEAR colour 0x00 with cmd_valid held high during busy -> 76800 writes covering addresses 0..76799 in order, second command not accepted until T+76803.
- With SPU_FB_BACKPRESSURE_EN, RECT 2x1 with fb_ready low for 3 cycles on the first write -> fb_addr held during the stall, two completed writes, done delayed by 3 cycles.
